pc_fetch_queue: RTL and testbench

Instruction fetch stage directly downstream of the locked program-counter register. Samples the PC value and lock status, issues one fetch request at a time to instruction memory over a valid/ready handshake, and buffers returned words, tagged with their PC, in a small FIFO for the decode stage. While the lock is set, fetches into a protected address window are refused and raise a sticky fault.

---
 rtl/pc_fetch_queue.sv | 132 +++++++++++++
 tb/tb_pc_fetch_queue.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_queue.sv
// Fetch stage: samples the locked PC, issues one fetch at a time and queues {pc, word} for decode.
// Optional build macro PC_ALIGN_CHECK_EN turns misaligned PCs into faults instead of masking bits [1:0].
module pc_fetch_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] PROT_BASE  = 32'h0000_F000,
  parameter logic [31:0] PROT_LIMIT = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] program_counter,
  input  logic        lock_status,
  input  logic        flush,
  output logic        req_valid,
  output logic [31:0] req_addr,
  input  logic        req_ready,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        fault
);
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, FAULT} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  state_t        state_q, state_d;
  logic [31:0]   addr_q;
  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  logic          full, sample, push, pop;
  logic [31:0]   pc_s;
  logic          prot_s, bad_s;

  assign full = (count_q == FULL_CNT);

`ifdef PC_ALIGN_CHECK_EN
  assign pc_s  = program_counter;
  assign bad_s = prot_s || (program_counter[1:0] != 2'b00);
`else
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^program_counter[1:0];
  assign pc_s  = {program_counter[31:2], 2'b00};
  assign bad_s = prot_s;
`endif

  assign prot_s = lock_status && (pc_s >= PROT_BASE) && (pc_s < PROT_LIMIT);

  always_comb begin
    state_d = state_q;
    sample  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!full) begin
          sample  = 1'b1;
          state_d = bad_s ? FAULT : REQ;
        end
      end
      REQ:     if (req_ready) state_d = WAIT;
      WAIT:    if (rsp_valid) state_d = IDLE;
      DRAIN:   if (rsp_valid) state_d = IDLE;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
    // Flush overrides everything; an accepted request still owes a response, so
    // that response must be drained before the next fetch can be trusted.
    if (flush) begin
      sample = 1'b0;
      case (state_q)
        REQ:     state_d = req_ready ? DRAIN : IDLE;
        WAIT:    state_d = rsp_valid ? IDLE : DRAIN;
        DRAIN:   state_d = rsp_valid ? IDLE : DRAIN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (sample) addr_q <= pc_s;
    end
  end

  assign push = (state_q == WAIT) && rsp_valid && !flush;
  assign pop  = inst_valid && inst_ready && !flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= '{pc: addr_q, data: rsp_data};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Head is read from registered storage only, so rsp_* never reaches inst_* combinationally.
  assign req_valid  = (state_q == REQ);
  assign req_addr   = addr_q;
  assign fault      = (state_q == FAULT);
  assign inst_valid = (count_q != '0);
  assign inst_data  = mem_q[rd_ptr_q].data;
  assign inst_pc    = mem_q[rd_ptr_q].pc;

endmodule

// File: tb/tb_pc_fetch_queue.sv
// Scoreboard bench for pc_fetch_queue: a behavioural memory/decode model pushes expected
// {pc, word} pairs; an independent negedge monitor pops and compares what decode sees.
module tb_pc_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] program_counter;
  logic        lock_status;
  logic        flush;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        fault;

  pc_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .program_counter(program_counter),
    .lock_status(lock_status), .flush(flush),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
  exp_t        exp_q[$];
  int          checks = 0, failures = 0;
  bit          chk_en = 0;
  logic [31:0] exp_addr;
  bit          outstanding = 0, discard = 0, auto_pc = 1, flush_on_hs = 0;
  logic [31:0] out_pc, out_data, next_data;
  int          wait_cnt = 0, rsp_delay = 0;
  int          rdy_pct = 100, pop_pct = 0, flush_pct = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] amask(input logic [31:0] p);
`ifdef PC_ALIGN_CHECK_EN
    return p;
`else
    return {p[31:2], 2'b00};
`endif
  endfunction

  // PCs that never fall inside the protected window, including both window edges.
  function automatic logic [31:0] safe_pc();
    logic [31:0] p;
    case ($urandom_range(0, 3))
      0:       p = 32'h0000_EFFC;
      1:       p = 32'h0001_0000;
      2:       p = $urandom_range(0, 32'h0000_EFFC);
      default: p = 32'h0001_0000 + $urandom_range(0, 32'h0000_FFFF);
    endcase
`ifdef PC_ALIGN_CHECK_EN
    p[1:0] = 2'b00;
`endif
    return p;
  endfunction

  // Monitor: compares everything decode and memory see against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (req_valid) begin
          chk("req_addr", req_addr, exp_addr);
          chk("req_while_full", exp_q.size() < DEPTH, 1);
        end
        chk("inst_valid", inst_valid, exp_q.size() != 0);
        if (inst_valid && exp_q.size() != 0) begin
          chk("inst_pc", inst_pc, exp_q[0].pc);
          chk("inst_data", inst_data, exp_q[0].data);
          if (inst_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // One clock of memory/decode behaviour plus model update for the edge just taken.
  task automatic step(output bit hs, output bit rs, output bit rv);
    bit fl;
    @(negedge clk);
    hs = req_valid && req_ready;
    rs = rsp_valid;
    rv = req_valid;
    fl = flush;
    @(posedge clk);
    #1;
    if (rs && outstanding) begin
      outstanding = 0;
      if (!discard && !fl) exp_q.push_back('{pc: out_pc, data: out_data});
    end
    if (fl) exp_q.delete();
    if (hs) begin
      outstanding = 1;
      discard     = fl;
      out_pc      = exp_addr;
      out_data    = next_data;
      next_data   = $urandom;
      wait_cnt    = (rsp_delay < 0) ? $urandom_range(0, 3) : rsp_delay;
      if (auto_pc) begin
        program_counter = safe_pc();
        exp_addr        = amask(program_counter);
      end
    end else if (fl && outstanding) begin
      discard = 1;
    end
    rsp_valid = 1'b0;
    rsp_data  = $urandom;
    if (outstanding) begin
      if (wait_cnt == 0) begin
        rsp_valid = 1'b1;
        rsp_data  = out_data;
      end else begin
        wait_cnt--;
      end
    end
    req_ready  = ($urandom_range(0, 99) < rdy_pct);
    inst_ready = ($urandom_range(0, 99) < pop_pct);
    flush      = (hs && flush_on_hs) || ($urandom_range(0, 99) < flush_pct);
  endtask

  task automatic quiesce();
    bit hs, rs, rv;
    int n = 0;
    rdy_pct = 0;
    do begin
      step(hs, rs, rv);
      n++;
    end while ((outstanding || req_ready) && n < 20);
    chk("quiesce_timeout", outstanding, 0);
  endtask

  // Flush to a clean IDLE, then let one sample of pcv happen and check its outcome.
  task automatic probe(input string nm, input logic [31:0] pcv, input logic lk,
                       input bit expf, input logic [31:0] eaddr);
    bit hs, rs, rv;
    pop_pct = 100;
    flush_pct = 0;
    quiesce();
    program_counter = pcv;
    lock_status     = lk;
    exp_addr        = eaddr;
    auto_pc         = 0;
    flush           = 1'b1;
    rdy_pct         = 100;
    step(hs, rs, rv);
    chk({nm, "_fault_clr"}, fault, 0);
    step(hs, rs, rv);
    chk({nm, "_fault"}, fault, expf);
    chk({nm, "_req_valid"}, req_valid, !expf);
    if (!expf) begin
      chk({nm, "_req_addr"}, req_addr, eaddr);
      step(hs, rs, rv);
      chk({nm, "_hs"}, hs, 1);
    end
  endtask

  initial begin
    bit hs, rs, rv;
    int n;
    logic [31:0] orig;
    resetn = 1'b0; program_counter = 32'h100; lock_status = 1'b0; flush = 1'b0;
    req_ready = 1'b1; rsp_valid = 1'b0; rsp_data = '0; inst_ready = 1'b0;
    exp_addr = 32'h100; next_data = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_req_addr", req_addr, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst_data", inst_data, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_fault", fault, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    chk_en = 1;

    // First fetch: PC sampled in cycle 0, request in cycle 1, word visible after response.
    step(hs, rs, rv);
    chk("t1_req_valid", req_valid, 1);
    chk("t1_req_addr", req_addr, 32'h100);
    step(hs, rs, rv);
    step(hs, rs, rv);
    chk("t1_inst_valid", inst_valid, 1);
    chk("t1_inst_pc", inst_pc, 32'h100);
    chk("t1_inst_data", inst_data, 32'hDEAD_BEEF);

    // Back-pressure: FIFO fills to DEPTH and fetching stops until one pop.
    n = 0;
    repeat (20) begin step(hs, rs, rv); n += hs; end
    chk("full_fetches", n, DEPTH - 1);
    chk("full_no_req", req_valid, 0);
    n = 0;
    pop_pct = 100; step(hs, rs, rv); n += hs;
    pop_pct = 0;
    repeat (11) begin step(hs, rs, rv); n += hs; end
    chk("refill_fetches", n, 1);

    // Flush while waiting on memory: the late response is dropped, then fetching resumes.
    pop_pct = 100; step(hs, rs, rv);
    pop_pct = 0; rsp_delay = 2; flush_on_hs = 1;
    hs = 0;
    for (int i = 0; i < 10 && !hs; i++) step(hs, rs, rv);
    chk("fw_hs_seen", hs, 1);
    flush_on_hs = 0;
    n = 0; rs = 0;
    for (int i = 0; i < 10 && !rs; i++) begin step(hs, rs, rv); n += hs; end
    chk("fw_rsp_seen", rs, 1);
    chk("fw_no_req_in_drain", n, 0);
    chk("fw_fifo_empty", inst_valid, 0);
    hs = 0;
    for (int i = 0; i < 10 && !hs; i++) step(hs, rs, rv);
    chk("fw_next_req", hs, 1);
    rsp_delay = 0;

    // Protection: fault is sticky until flush, then the same PC fetches when unlocked.
    probe("prot_f004", 32'h0000_F004, 1'b1, 1, 32'h0000_F004);
    rdy_pct = 100;
    repeat (5) begin
      step(hs, rs, rv);
      chk("prot_hold_fault", fault, 1);
      chk("prot_hold_noreq", req_valid, 0);
    end
    probe("unlock_f004", 32'h0000_F004, 1'b0, 0, 32'h0000_F004);
    probe("edge_f000", 32'h0000_F000, 1'b1, 1, 32'h0000_F000);
    probe("edge_fffc", 32'h0000_FFFC, 1'b1, 1, 32'h0000_FFFC);
    probe("edge_10000", 32'h0001_0000, 1'b1, 0, 32'h0001_0000);
`ifdef PC_ALIGN_CHECK_EN
    probe("align_102", 32'h0000_0102, 1'b0, 1, 32'h0000_0102);
`else
    probe("align_102", 32'h0000_0102, 1'b0, 0, 32'h0000_0100);
`endif
    probe("edge_effc", 32'h0000_EFFC, 1'b1, 0, 32'h0000_EFFC);

    // Request must hold its address while memory stalls and the PC keeps moving.
    quiesce();
    auto_pc = 0;
    exp_addr = amask(program_counter);
    flush = 1'b1;
    step(hs, rs, rv);
    rv = 0;
    for (int i = 0; i < 10 && !rv; i++) step(hs, rs, rv);
    chk("stall_req_seen", rv, 1);
    orig = program_counter;
    for (int i = 0; i < 5; i++) begin
      program_counter = $urandom;
      step(hs, rs, rv);
      chk("stall_req_valid", req_valid, 1);
      chk("stall_req_addr", req_addr, amask(orig));
    end
    program_counter = orig;
    rdy_pct = 100;
    auto_pc = 1;
    hs = 0;
    for (int i = 0; i < 5 && !hs; i++) step(hs, rs, rv);
    chk("stall_release_hs", hs, 1);

    // Randomized traffic with flushes, stalls and lock toggling over safe PCs.
    rdy_pct = 70; pop_pct = 60; flush_pct = 3; rsp_delay = -1;
    for (int i = 0; i < 800; i++) begin
      if (i % 64 == 0) lock_status = $urandom_range(0, 1);
      step(hs, rs, rv);
      chk("rand_no_fault", fault, 0);
    end

    rdy_pct = 0; pop_pct = 100; flush_pct = 0;
    repeat (30) step(hs, rs, rv);
    chk("drain_empty", inst_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
